// File: rtl/sram_req_responder.sv
// Request responder between an arbiter and a pipelined ZBT SRAM.
// Accepts one request per cycle after power-up and completes reads and writes in order.
module sram_req_responder #(
    parameter int ADDR_WIDTH     = 18,
    parameter int DATA_WIDTH     = 32,
    parameter int POWERUP_CYCLES = 16
) (
    input  logic                  sram_clock,
    input  logic                  reset,
    input  logic                  sram_addr_valid,
    output logic                  sram_ready,
    input  logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_data_in,
    input  logic [3:0]            sram_write_mask,
    output logic [DATA_WIDTH-1:0] sram_data_out,
    output logic                  sram_data_out_valid,
    output logic [ADDR_WIDTH-1:0] zbt_addr,
    output logic                  zbt_ce_b,
    output logic                  zbt_we_b,
    output logic [3:0]            zbt_bw_b,
    output logic [DATA_WIDTH-1:0] zbt_dq_out,
    output logic                  zbt_dq_oe,
    input  logic [DATA_WIDTH-1:0] zbt_dq_in
);

    // Counter spans 0..POWERUP_CYCLES-1; POWERUP_CYCLES must be at least 1.
    localparam int PW = (POWERUP_CYCLES < 2) ? 1 : $clog2(POWERUP_CYCLES);
    localparam logic [PW-1:0] POWERUP_LAST = PW'(POWERUP_CYCLES - 1);

    logic [PW-1:0] powerup_count;
    logic          accept;

    logic                  s1_valid;
    logic                  s1_write;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [3:0]            s1_mask;
    logic [DATA_WIDTH-1:0] s1_data;

    logic                  s2_valid;
    logic                  s2_write;
    logic [DATA_WIDTH-1:0] s2_data;

    logic                  s3_valid;
    logic                  s3_write;
    logic [DATA_WIDTH-1:0] s3_data;

    logic                  read_sample;

    assign accept = sram_addr_valid & sram_ready;

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            powerup_count <= '0;
            sram_ready    <= 1'b0;
        end else if (!sram_ready) begin
            powerup_count <= powerup_count + 1'b1;
            if (powerup_count == POWERUP_LAST) begin
                sram_ready <= 1'b1;
            end
        end
    end

    // Stage 1: capture the accepted request.
    always_ff @(posedge sram_clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_write <= 1'b0;
            s1_addr  <= '0;
            s1_mask  <= 4'h0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_write <= (sram_write_mask != 4'h0);
                s1_addr  <= sram_addr;
                s1_mask  <= sram_write_mask;
                s1_data  <= sram_data_in;
            end
        end
    end

    // Command cycle on the SRAM pins; the address holds between commands.
    always_ff @(posedge sram_clock) begin
        if (reset) begin
            zbt_addr <= '0;
            zbt_ce_b <= 1'b1;
            zbt_we_b <= 1'b1;
            zbt_bw_b <= 4'hF;
        end else if (s1_valid) begin
            zbt_addr <= s1_addr;
            zbt_ce_b <= 1'b0;
            zbt_we_b <= ~s1_write;
            zbt_bw_b <= s1_write ? ~s1_mask : 4'hF;
        end else begin
            zbt_ce_b <= 1'b0 | 1'b1;
            zbt_we_b <= 1'b1;
            zbt_bw_b <= 4'hF;
        end
    end

    // Stages 2 and 3 carry op type and write data until the SRAM data phase.
    always_ff @(posedge sram_clock) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_write <= 1'b0;
            s2_data  <= '0;
            s3_valid <= 1'b0;
            s3_write <= 1'b0;
            s3_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_write <= s1_write;
            s2_data  <= s1_data;
            s3_valid <= s2_valid;
            s3_write <= s2_write;
            s3_data  <= s2_data;
        end
    end

    // Data phase: drive write data, or arm the read sample for the next edge.
    always_ff @(posedge sram_clock) begin
        if (reset) begin
            zbt_dq_oe   <= 1'b0;
            zbt_dq_out  <= '0;
            read_sample <= 1'b0;
        end else begin
            zbt_dq_oe   <= s3_valid & s3_write;
            read_sample <= s3_valid & ~s3_write;
            if (s3_valid && s3_write) begin
                zbt_dq_out <= s3_data;
            end
        end
    end

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            sram_data_out       <= '0;
            sram_data_out_valid <= 1'b0;
        end else begin
            sram_data_out_valid <= read_sample;
            if (read_sample) begin
                sram_data_out <= zbt_dq_in;
            end
        end
    end

endmodule

// File: tb/tb_sram_req_responder.sv
// Bench for sram_req_responder: behavioural ZBT SRAM, reference memory and
// an in-order read-return scoreboard.
module tb_sram_req_responder;

    logic        sram_clock = 1'b0;
    logic        reset = 1'b1;
    logic        sram_addr_valid = 1'b0;
    logic        sram_ready;
    logic [17:0] sram_addr = '0;
    logic [31:0] sram_data_in = '0;
    logic [3:0]  sram_write_mask = 4'h0;
    logic [31:0] sram_data_out;
    logic        sram_data_out_valid;
    logic [17:0] zbt_addr;
    logic        zbt_ce_b;
    logic        zbt_we_b;
    logic [3:0]  zbt_bw_b;
    logic [31:0] zbt_dq_out;
    logic        zbt_dq_oe;
    logic [31:0] zbt_dq_in = '0;

    int n_checks = 0;
    int n_pass = 0;
    int oe_err = 0;
    int strobe_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    bit [31:0] ref_mem[int];
    bit [31:0] zbt_mem[int];

    localparam logic [90:0] RESET_OUTS = {1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 18'h0, 1'b0, 32'h0};

    sram_req_responder dut (
        .sram_clock          (sram_clock),
        .reset               (reset),
        .sram_addr_valid     (sram_addr_valid),
        .sram_ready          (sram_ready),
        .sram_addr           (sram_addr),
        .sram_data_in        (sram_data_in),
        .sram_write_mask     (sram_write_mask),
        .sram_data_out       (sram_data_out),
        .sram_data_out_valid (sram_data_out_valid),
        .zbt_addr            (zbt_addr),
        .zbt_ce_b            (zbt_ce_b),
        .zbt_we_b            (zbt_we_b),
        .zbt_bw_b            (zbt_bw_b),
        .zbt_dq_out          (zbt_dq_out),
        .zbt_dq_oe           (zbt_dq_oe),
        .zbt_dq_in           (zbt_dq_in)
    );

    // Clock / reset block
    always #5 sram_clock = ~sram_clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ZBT SRAM model: command seen in one cycle, data phase two cycles later.
    logic        p0_v = 1'b0, p1_v = 1'b0, p0_w = 1'b0, p1_w = 1'b0;
    logic [17:0] p0_a = '0, p1_a = '0;
    logic [3:0]  p0_bw = 4'hF, p1_bw = 4'hF;

    always @(negedge sram_clock) begin
        bit [31:0] word;
        #1;
        if (reset) begin
            p0_v = 1'b0;
            p1_v = 1'b0;
        end else begin
            if (p1_v && p1_w) begin
                if (zbt_dq_oe !== 1'b1) oe_err++;
                word = zbt_mem.exists(int'(p1_a)) ? zbt_mem[int'(p1_a)] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (!p1_bw[b]) word[8*b +: 8] = zbt_dq_out[8*b +: 8];
                zbt_mem[int'(p1_a)] = word;
                zbt_dq_in = $urandom();
            end else begin
                if (zbt_dq_oe !== 1'b0) oe_err++;
                if (p1_v) zbt_dq_in = zbt_mem.exists(int'(p1_a)) ? zbt_mem[int'(p1_a)] : 32'h0;
                else      zbt_dq_in = $urandom();
            end
            p1_v = p0_v; p1_w = p0_w; p1_a = p0_a; p1_bw = p0_bw;
            p0_v = (zbt_ce_b === 1'b0);
            p0_w = (zbt_we_b === 1'b0);
            p0_a = zbt_addr;
            p0_bw = zbt_bw_b;
        end
    end

    // Read-return monitor
    always @(negedge sram_clock) begin
        if (sram_data_out_valid === 1'b1) begin
            got_q.push_back(sram_data_out);
            strobe_cnt++;
        end
    end

    // Driver tasks
    task automatic issue(input bit wr, input logic [17:0] a, input logic [31:0] d, input logic [3:0] m);
        bit [31:0] w;
        sram_addr_valid = 1'b1;
        sram_addr = a;
        sram_data_in = d;
        sram_write_mask = wr ? m : 4'h0;
        w = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
        if (wr && m != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (m[b]) w[8*b +: 8] = d[8*b +: 8];
            ref_mem[int'(a)] = w;
        end else begin
            exp_q.push_back(w);
        end
        @(negedge sram_clock);
    endtask

    task automatic idle(input int n);
        sram_addr_valid = 1'b0;
        sram_write_mask = 4'h0;
        repeat (n) @(negedge sram_clock);
    endtask

    task automatic check_scoreboard(input string name);
        int waited = 0;
        logic [31:0] e, g;
        while (got_q.size() != exp_q.size() && waited < 40) begin
            @(negedge sram_clock);
            waited++;
        end
        n_checks++;
        if (got_q.size() != exp_q.size())
            $display("FAIL %s strobe count: got %0d expected %0d", name, got_q.size(), exp_q.size());
        else n_pass++;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) $display("FAIL %s read data: got %h expected %h", name, g, e);
            else n_pass++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic count_powerup(input string name);
        int low = 0;
        while (sram_ready !== 1'b1 && low < 40) begin
            low++;
            @(negedge sram_clock);
        end
        n_checks++;
        if (low !== 16) $display("FAIL %s ready-low cycles: got %0d expected 16", name, low);
        else n_pass++;
    endtask

    // Tests
    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sram_addr_valid = 1'($urandom_range(0, 1));
            sram_addr = 18'($urandom());
            sram_write_mask = 4'($urandom());
            @(negedge sram_clock);
            n_checks++;
            if ({sram_ready, sram_data_out_valid, sram_data_out, zbt_ce_b, zbt_we_b, zbt_bw_b,
                 zbt_addr, zbt_dq_oe, zbt_dq_out} !== RESET_OUTS)
                $display("FAIL reset_outputs: got %h expected %h",
                         {sram_ready, sram_data_out_valid, sram_data_out, zbt_ce_b, zbt_we_b, zbt_bw_b,
                          zbt_addr, zbt_dq_oe, zbt_dq_out}, RESET_OUTS);
            else n_pass++;
        end
        sram_addr_valid = 1'b1;
        sram_addr = 18'h00abc;
        sram_write_mask = 4'h0;
        exp_q.push_back(32'h0);
        reset = 1'b0;
        count_powerup("powerup");
        @(negedge sram_clock);
        sram_addr_valid = 1'b0;
        n_checks++;
        if (zbt_ce_b !== 1'b1) $display("FAIL first_accept ce_b before command: got %b expected 1", zbt_ce_b);
        else n_pass++;
        @(negedge sram_clock);
        n_checks++;
        if ({zbt_ce_b, zbt_we_b, zbt_bw_b, zbt_addr} !== {1'b0, 1'b1, 4'hF, 18'h00abc})
            $display("FAIL first_accept command: got %b %b %h %h expected 0 1 f 00abc",
                     zbt_ce_b, zbt_we_b, zbt_bw_b, zbt_addr);
        else n_pass++;
        check_scoreboard("first_read");
    endtask

    task automatic test_write_read();
        issue(1'b1, 18'h00010, 32'hDEADBEEF, 4'hF);
        issue(1'b0, 18'h00010, 32'h0, 4'h0);
        sram_addr_valid = 1'b0;
        n_checks++;
        if ({zbt_ce_b, zbt_we_b, zbt_bw_b, zbt_addr} !== {1'b0, 1'b0, 4'h0, 18'h00010})
            $display("FAIL wr_rd write command: got %b %b %h %h expected 0 0 0 00010",
                     zbt_ce_b, zbt_we_b, zbt_bw_b, zbt_addr);
        else n_pass++;
        @(negedge sram_clock);
        n_checks++;
        if ({zbt_ce_b, zbt_we_b, zbt_bw_b, zbt_dq_oe} !== {1'b0, 1'b1, 4'hF, 1'b0})
            $display("FAIL wr_rd read command: got %b %b %h oe %b expected 0 1 f oe 0",
                     zbt_ce_b, zbt_we_b, zbt_bw_b, zbt_dq_oe);
        else n_pass++;
        @(negedge sram_clock);
        n_checks++;
        if ({zbt_dq_oe, zbt_dq_out} !== {1'b1, 32'hDEADBEEF})
            $display("FAIL wr_rd write data: got oe %b %h expected oe 1 deadbeef", zbt_dq_oe, zbt_dq_out);
        else n_pass++;
        @(negedge sram_clock);
        n_checks++;
        if ({zbt_dq_oe, sram_data_out_valid} !== 2'b00)
            $display("FAIL wr_rd after data: got oe %b valid %b expected 0 0", zbt_dq_oe, sram_data_out_valid);
        else n_pass++;
        @(negedge sram_clock);
        n_checks++;
        if ({sram_data_out_valid, sram_data_out} !== {1'b1, 32'hDEADBEEF})
            $display("FAIL wr_rd read latency: got valid %b %h expected 1 deadbeef",
                     sram_data_out_valid, sram_data_out);
        else n_pass++;
        @(negedge sram_clock);
        n_checks++;
        if ({sram_data_out_valid, sram_data_out} !== {1'b0, 32'hDEADBEEF})
            $display("FAIL wr_rd hold: got valid %b %h expected 0 deadbeef", sram_data_out_valid, sram_data_out);
        else n_pass++;
        check_scoreboard("wr_rd");
    endtask

    task automatic test_partial();
        issue(1'b1, 18'h00020, 32'h11223344, 4'hF);
        issue(1'b1, 18'h00020, 32'hAABBCCDD, 4'b0101);
        issue(1'b0, 18'h00020, 32'h0, 4'h0);
        sram_addr_valid = 1'b0;
        n_checks++;
        if ({zbt_we_b, zbt_bw_b} !== {1'b0, 4'b1010})
            $display("FAIL partial byte enables: got we %b bw %b expected we 0 bw 1010", zbt_we_b, zbt_bw_b);
        else n_pass++;
        check_scoreboard("partial");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) issue(1'b1, 18'(18'h100 + i), $urandom(), 4'hF);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (sram_ready !== 1'b1) $display("FAIL b2b ready op %0d: got %b expected 1", i, sram_ready);
            else n_pass++;
            issue(i[0], 18'(18'h100 + i), $urandom(), 4'hF);
        end
        idle(1);
        check_scoreboard("b2b_alternating");
        for (int i = 0; i < 24; i++)
            issue(1'($urandom_range(0, 1)), 18'(18'h100 + $urandom_range(0, 7)), $urandom(),
                  4'($urandom_range(0, 15)));
        idle(1);
        check_scoreboard("b2b_random");
    endtask

    task automatic test_idle();
        idle(2);
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if ({zbt_ce_b, zbt_dq_oe, sram_data_out_valid} !== 3'b100)
                $display("FAIL idle cycle %0d: got ce_b/oe/valid %b expected 100", i,
                         {zbt_ce_b, zbt_dq_oe, sram_data_out_valid});
            else n_pass++;
            @(negedge sram_clock);
        end
    endtask

    task automatic test_reset_flush();
        int strobes_before;
        int oe_before;
        issue(1'b1, 18'h00030, 32'hCAFEF00D, 4'hF);
        issue(1'b0, 18'h00031, 32'h0, 4'h0);
        idle(1);
        reset = 1'b1;
        void'(exp_q.pop_back());
        strobes_before = strobe_cnt;
        oe_before = oe_err;
        @(negedge sram_clock);
        n_checks++;
        if ({sram_ready, sram_data_out_valid, sram_data_out, zbt_ce_b, zbt_we_b, zbt_bw_b,
             zbt_addr, zbt_dq_oe, zbt_dq_out} !== RESET_OUTS)
            $display("FAIL flush reset_outputs: got %h expected %h",
                     {sram_ready, sram_data_out_valid, sram_data_out, zbt_ce_b, zbt_we_b, zbt_bw_b,
                      zbt_addr, zbt_dq_oe, zbt_dq_out}, RESET_OUTS);
        else n_pass++;
        repeat (2) @(negedge sram_clock);
        reset = 1'b0;
        count_powerup("flush_powerup");
        idle(4);
        n_checks++;
        if (strobe_cnt !== strobes_before)
            $display("FAIL flush read strobe: got %0d strobes expected %0d", strobe_cnt, strobes_before);
        else n_pass++;
        n_checks++;
        if (oe_err !== oe_before) $display("FAIL flush write drive: got %0d oe errors expected %0d", oe_err, oe_before);
        else n_pass++;
        issue(1'b1, 18'h00040, 32'h5A5A0FF0, 4'hF);
        issue(1'b0, 18'h00040, 32'h0, 4'h0);
        idle(1);
        check_scoreboard("after_flush");
    endtask

    initial begin
        idle(2);
        test_reset();
        test_write_read();
        test_partial();
        test_back_to_back();
        test_idle();
        test_reset_flush();
        n_checks++;
        if (oe_err !== 0) $display("FAIL data_phase oe: got %0d errors expected 0", oe_err);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
